ip_zero_sched: RTL

- Job sequencer in front of the planar/DC/angular-zero intra-prediction wrapper.
- Per job it:
  - accepts a 13-bit configuration word;
  - streams the block's reference words into the two mirrored 32x64 reference memories (the shared wdata/wraddress/wren write port);
  - issues the configuration word to the core's conf_in FIFO;
  - monitors the hor/ver output handshakes until the block is complete, then reports done.
- Because reference memory is single-buffered, the next job's reference load is held off until the current job finishes.

---
 rtl/ip_zero_pkg.sv | 33 +++
 rtl/ip_zero_beat_cnt.sv | 58 +++++
 rtl/ip_zero_sched.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/ip_zero_pkg.sv
// Shared definitions for the intra-prediction zero-mode job sequencer.
// Provides the bus widths, the sequencer state encoding and the per-size
// word-count helpers used by the top and the beat counters.
package ip_zero_pkg;

    localparam int unsigned DATA_W   = 32;   // reference word, 4 x 8-bit samples
    localparam int unsigned ADDR_W   = 6;    // reference memory address
    localparam int unsigned CONF_W   = 13;   // configuration word
    localparam int unsigned SIZE_LSB = 10;   // LSB of the 3-bit size code
    localparam int unsigned SIZE_W   = 3;
    localparam int unsigned CNT_W    = 9;    // holds up to 256 output words
    localparam int unsigned MAX_SIZE = 3;    // largest legal size code

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        ISSUE,
        RUN,
        DONE
    } state_e;

    // Reference words per block: N + 1 with N = 4 << s.
    function automatic logic [CNT_W-1:0] ref_words(input logic [SIZE_W-1:0] s);
        return CNT_W'((32'd4 << s) + 32'd1);
    endfunction

    // Output words per direction: N*N/4 = 4 << (2*s).
    function automatic logic [CNT_W-1:0] out_words(input logic [SIZE_W-1:0] s);
        return CNT_W'(32'd4 << {s, 1'b0});
    endfunction

endpackage

// File: rtl/ip_zero_beat_cnt.sv
// Saturating beat counter for one output direction of the prediction core.
// Ports:
//   clk, arst   clock, asynchronous active-high reset
//   clr_i       synchronous clear (start of a new block)
//   en_i        counting window (core running)
//   beat_i      observed valid&ready beat
//   max_i       terminal count for the current block
//   tc_o        count has reached max_i (registered)
//   ovf_o       one-cycle strobe: a beat arrived while already at max_i
module ip_zero_beat_cnt
    import ip_zero_pkg::*;
(
    input  logic             clk,
    input  logic             arst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             beat_i,
    input  logic [CNT_W-1:0] max_i,
    output logic             tc_o,
    output logic             ovf_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;

    // Next count: clear wins, otherwise count up and hold at max_i.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && beat_i) begin
            if (cnt_q == max_i) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        tc_d = (cnt_d == max_i);
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cnt_q <= '0;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
        end
    end

    assign tc_o  = tc_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/ip_zero_sched.sv
// Job sequencer in front of the planar/DC/angular-zero prediction wrapper.
// Per job: accept a configuration word, stream the block's reference words
// into the mirrored reference memories, issue the configuration to the core
// and watch the hor/ver output handshakes until the block is complete.
// Ports:
//   clk, arst                      clock, asynchronous active-high reset
//   job_in_dat/vld/rdy             job configuration stream
//   ref_in_dat/vld/rdy             reference word stream
//   wdata, wraddress, wren         reference memory write port
//   conf_out_dat/vld/rdy           configuration to the core conf_in FIFO
//   hor_mon_vld/rdy, ver_mon_vld/rdy  taps of the core output handshakes
//   done                           one-cycle pulse at job completion
//   busy                           job in progress
//   err                            sticky protocol error
module ip_zero_sched
    import ip_zero_pkg::*;
(
    input  logic              clk,
    input  logic              arst,
    input  logic [CONF_W-1:0] job_in_dat,
    input  logic              job_in_vld,
    output logic              job_in_rdy,
    input  logic [DATA_W-1:0] ref_in_dat,
    input  logic              ref_in_vld,
    output logic              ref_in_rdy,
    output logic [DATA_W-1:0] wdata,
    output logic [ADDR_W-1:0] wraddress,
    output logic              wren,
    output logic [CONF_W-1:0] conf_out_dat,
    output logic              conf_out_vld,
    input  logic              conf_out_rdy,
    input  logic              hor_mon_vld,
    input  logic              hor_mon_rdy,
    input  logic              ver_mon_vld,
    input  logic              ver_mon_rdy,
    output logic              done,
    output logic              busy,
    output logic              err
);

    state_e            state_q;
    logic [CONF_W-1:0] conf_q;
    logic [ADDR_W-1:0] addr_cnt_q;

    logic [SIZE_W-1:0] size_q;
    logic [CNT_W-1:0]  max_beats;
    logic [CNT_W-1:0]  last_addr;
    logic              hor_beat, ver_beat;
    logic              hor_tc, ver_tc;
    logic              hor_ovf, ver_ovf;
    logic              cnt_clr, cnt_en;
    logic              ref_hs, last_ref;
    logic              stray_beat;

    assign size_q     = conf_q[SIZE_LSB +: SIZE_W];
    assign max_beats  = out_words(size_q);
    assign last_addr  = ref_words(size_q) - CNT_W'(1);
    assign hor_beat   = hor_mon_vld & hor_mon_rdy;
    assign ver_beat   = ver_mon_vld & ver_mon_rdy;
    assign cnt_en     = (state_q == RUN);
    // Counters restart exactly when the core takes the configuration.
    assign cnt_clr    = (state_q == ISSUE) & conf_out_vld & conf_out_rdy;
    assign ref_hs     = ref_in_vld & ref_in_rdy;
    assign last_ref   = (CNT_W'(addr_cnt_q) == last_addr);
    assign stray_beat = (hor_beat | ver_beat) & (state_q != RUN);

    ip_zero_beat_cnt u_hor_cnt (
        .clk    (clk),
        .arst   (arst),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .beat_i (hor_beat),
        .max_i  (max_beats),
        .tc_o   (hor_tc),
        .ovf_o  (hor_ovf)
    );

    ip_zero_beat_cnt u_ver_cnt (
        .clk    (clk),
        .arst   (arst),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .beat_i (ver_beat),
        .max_i  (max_beats),
        .tc_o   (ver_tc),
        .ovf_o  (ver_ovf)
    );

    // Sequencer: all handshake and memory-port outputs are registered here.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q      <= IDLE;
            conf_q       <= '0;
            addr_cnt_q   <= '0;
            wdata        <= '0;
            wraddress    <= '0;
            wren         <= 1'b0;
            conf_out_dat <= '0;
            conf_out_vld <= 1'b0;
            job_in_rdy   <= 1'b0;
            ref_in_rdy   <= 1'b0;
            done         <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
        end else begin
            wren <= 1'b0;
            done <= 1'b0;
            if (stray_beat || hor_ovf || ver_ovf) begin
                err <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    job_in_rdy <= 1'b1;
                    if (job_in_vld && job_in_rdy) begin
                        conf_q <= job_in_dat;
                        if (job_in_dat[SIZE_LSB +: SIZE_W] > SIZE_W'(MAX_SIZE)) begin
                            // Unsupported block size: drop the job, keep accepting.
                            err <= 1'b1;
                        end else begin
                            job_in_rdy <= 1'b0;
                            busy       <= 1'b1;
                            ref_in_rdy <= 1'b1;
                            addr_cnt_q <= '0;
                            state_q    <= LOAD;
                        end
                    end
                end

                LOAD: begin
                    if (ref_hs) begin
                        wdata      <= ref_in_dat;
                        wraddress  <= addr_cnt_q;
                        wren       <= 1'b1;
                        addr_cnt_q <= addr_cnt_q + ADDR_W'(1);
                        if (last_ref) begin
                            ref_in_rdy <= 1'b0;
                            state_q    <= SETTLE;
                        end
                    end
                end

                // One gap cycle lets the final registered write land first.
                SETTLE: begin
                    conf_out_vld <= 1'b1;
                    conf_out_dat <= conf_q;
                    state_q      <= ISSUE;
                end

                ISSUE: begin
                    if (conf_out_rdy) begin
                        conf_out_vld <= 1'b0;
                        state_q      <= RUN;
                    end
                end

                RUN: begin
                    if (hor_tc && ver_tc) begin
                        done    <= 1'b1;
                        state_q <= DONE;
                    end
                end

                DONE: begin
                    busy       <= 1'b0;
                    job_in_rdy <= 1'b1;
                    state_q    <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
